// File: rtl/rega_zone_scheduler.sv
// Irrigation zone scheduler: shares one tank/pump path between NZ zones.
// Pending zones are served round-robin. Each service opens the zone valve,
// waits SETTLE ticks, runs the pump for the programmed number of ticks, stops
// the pump and holds the valve SETTLE more ticks. An empty tank pauses the
// service and raises a refill request. The retained tick count is resumed
// once the tank is full again.
module rega_zone_scheduler #(
  parameter int unsigned NZ     = 4,
  parameter int unsigned TW     = 8,
  parameter int unsigned SETTLE = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic [NZ-1:0]    zone_req,
  input  logic [NZ*TW-1:0] zone_dur,
  input  logic [2:0]       nv,
  input  logic             fill_busy,
  output logic [NZ-1:0]    zone_valve,
  output logic             pump_en,
  output logic [NZ-1:0]    zone_done,
  output logic             refill_req,
  output logic             busy,
  output logic [2:0]       cur_zone,
  output logic             sensor_fault
);

  localparam int unsigned IW = $clog2(NZ);
  localparam int unsigned SW = $clog2(SETTLE + 1);
  localparam logic [SW-1:0] SettleLd = SW'(SETTLE);

  typedef logic [IW:0] cand_t;

  typedef enum logic [2:0] {
    StIdle,
    StSelect,
    StOpen,
    StWater,
    StClose,
    StWaitTank
  } state_e;

  state_e        state_q;
  logic [IW-1:0] cur_q;
  logic [IW-1:0] rr_q;
  logic [SW-1:0] settle_q;
  logic [TW-1:0] remain_q;
  logic          done_pend_q;
  logic          pause_pend_q;
  logic          fault_q;

  logic          level_ok;
  logic          tank_empty;
  logic          tank_full;
  logic          grant_vld;
  logic [IW-1:0] grant_idx;
  logic [TW-1:0] grant_dur;
  logic [TW-1:0] dur_arr [NZ];
  cand_t         cand;
  logic          close_exit;

  // Wrap-around successor of a zone index.
  function automatic logic [IW-1:0] next_zone(input logic [IW-1:0] idx);
    return (idx == IW'(NZ - 1)) ? '0 : idx + IW'(1);
  endfunction

  // Tank level decode; any non-thermometer code reads as empty.
  always_comb begin
    level_ok   = (nv == 3'b000) || (nv == 3'b001) || (nv == 3'b011) || (nv == 3'b111);
    tank_empty = ~nv[0] | ~level_ok;
    tank_full  = nv[2] & level_ok;
  end

  // Unpack the per-zone duration bus.
  always_comb begin
    for (int unsigned i = 0; i < NZ; i++) begin
      dur_arr[i] = zone_dur[i*TW +: TW];
    end
  end

  // Round-robin arbiter: first requesting zone at or after the rr pointer.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NZ; k++) begin
      cand = {1'b0, rr_q} + cand_t'(k);
      if (cand >= cand_t'(NZ)) begin
        cand = cand - cand_t'(NZ);
      end
      if (!grant_vld && zone_req[cand[IW-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = cand[IW-1:0];
      end
    end
    grant_dur = dur_arr[grant_idx];
  end

  assign close_exit = (state_q == StClose) && tick && (settle_q == SW'(1));

  // Sequencer: arbitration, valve/pump phases and tank pause handling.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      cur_q        <= '0;
      rr_q         <= '0;
      settle_q     <= '0;
      remain_q     <= '0;
      done_pend_q  <= 1'b0;
      pause_pend_q <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      if (!level_ok) begin
        fault_q <= 1'b1;
      end
      unique case (state_q)
        StIdle: begin
          if (|zone_req) begin
            state_q <= StSelect;
          end
        end
        StSelect: begin
          if (!grant_vld) begin
            state_q <= StIdle;
          end else begin
            cur_q        <= grant_idx;
            remain_q     <= grant_dur;
            done_pend_q  <= 1'b0;
            pause_pend_q <= 1'b0;
            if (grant_dur == '0) begin
              rr_q    <= next_zone(grant_idx);
              state_q <= StIdle;
            end else if (tank_empty) begin
              state_q <= StWaitTank;
            end else begin
              settle_q <= SettleLd;
              state_q  <= StOpen;
            end
          end
        end
        StOpen: begin
          if (tick) begin
            settle_q <= settle_q - SW'(1);
            if (settle_q == SW'(1)) begin
              state_q <= StWater;
            end
          end
        end
        StWater: begin
          // Empty wins over completion, completion over abort.
          if (tank_empty) begin
            pause_pend_q <= 1'b1;
            settle_q     <= SettleLd;
            state_q      <= StClose;
          end else if (tick && (remain_q == TW'(1))) begin
            remain_q    <= '0;
            done_pend_q <= 1'b1;
            settle_q    <= SettleLd;
            state_q     <= StClose;
          end else if (!zone_req[cur_q]) begin
            settle_q <= SettleLd;
            state_q  <= StClose;
          end else if (tick) begin
            remain_q <= remain_q - TW'(1);
          end
        end
        StClose: begin
          if (tick) begin
            settle_q <= settle_q - SW'(1);
          end
          if (close_exit) begin
            done_pend_q  <= 1'b0;
            pause_pend_q <= 1'b0;
            if (pause_pend_q && !done_pend_q) begin
              state_q <= StWaitTank;
            end else begin
              rr_q    <= next_zone(cur_q);
              state_q <= StIdle;
            end
          end
        end
        StWaitTank: begin
          if (!zone_req[cur_q]) begin
            rr_q    <= next_zone(cur_q);
            state_q <= StIdle;
          end else if (tank_full && !fill_busy) begin
            settle_q <= SettleLd;
            state_q  <= StOpen;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Drives decoded from the state registers so reset clears them at once.
  always_comb begin
    zone_valve = '0;
    pump_en    = 1'b0;
    refill_req = 1'b0;
    busy       = (state_q != StIdle);
    cur_zone   = 3'(cur_q);
    unique case (state_q)
      StIdle:     cur_zone = '0;
      StSelect:   cur_zone = grant_vld ? 3'(grant_idx) : 3'(cur_q);
      StOpen:     zone_valve[cur_q] = 1'b1;
      StWater: begin
        zone_valve[cur_q] = 1'b1;
        // Pump stops in the same cycle the tank reads empty.
        pump_en = ~tank_empty;
      end
      StClose:    zone_valve[cur_q] = 1'b1;
      StWaitTank: refill_req = 1'b1;
      default:    cur_zone = '0;
    endcase
  end

  // Completion pulses: zero-duration grant in SELECT, or CLOSE exit after a full run.
  always_comb begin
    zone_done = '0;
    if ((state_q == StSelect) && grant_vld && (grant_dur == '0)) begin
      zone_done[grant_idx] = 1'b1;
    end
    if (close_exit && done_pend_q) begin
      zone_done[cur_q] = 1'b1;
    end
  end

  assign sensor_fault = fault_q;

endmodule

// File: doc/rega_zone_scheduler.md
Name: rega_zone_scheduler

Overview:
Shares the single tank/pump water path between NZ irrigation zones. Serves pending zone requests round-robin. Each served zone gets a programmed number of watering ticks. Sequences valve-open settle, pump run and valve-close settle; pauses on empty tank and requests a refill from the tank-fill controller.

Parameters:
NZ, 4, number of irrigation zones (2..8)
TW, 8, width of per-zone duration and tick counters
SETTLE, 2, valve settle time in ticks before pump-on and after pump-off (>=1)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
tick  in  1  one-cycle time-base strobe; all durations counted in ticks
zone_req  in  NZ  level request per zone; bit i = zone i wants water
zone_dur  in  NZ*TW  duration per zone in ticks; zone i at [i*TW +: TW]
nv  in  3  tank level sensors, thermometer code, nv[0] lowest
fill_busy  in  1  refill controller currently filling
zone_valve  out  NZ  one-hot (or zero) zone valve drive
pump_en  out  1  pump drive
zone_done  out  NZ  one-cycle pulse when zone i completes its full duration
refill_req  out  1  level request to refill controller
busy  out  1  high in every state except IDLE
cur_zone  out  3  index of zone being served; 0 in IDLE
sensor_fault  out  1  sticky illegal-level flag

Behaviour:
- Reset (async): state IDLE; all outputs 0; rr pointer = 0 (zone 0 highest priority); counters 0.
- Level decode: empty = ~nv[0]; full = nv[2]. Legal codes are 000, 001, 011, 111. Any other code sets sensor_fault (sticky until reset) and is treated as empty.
- States: IDLE, SELECT, OPEN, WATER, CLOSE, WAIT_TANK.
- IDLE: if any zone_req bit is set, go to SELECT next cycle.
- SELECT, one cycle:
  - Grant the first requesting zone at or after rr pointer, wrapping modulo NZ; latch it into cur_zone.
  - If its zone_dur = 0: pulse zone_done[cur] this cycle, set rr = cur+1 mod NZ, return to IDLE; valve never opens.
  - Else if empty: go to WAIT_TANK.
  - Else: load remaining = zone_dur[cur], load settle counter = SETTLE, go to OPEN.
  - If the request vanished before SELECT: return to IDLE with no grant and rr unchanged.
- OPEN: zone_valve[cur] = 1, pump_en = 0. Settle counter decrements on tick; when it reaches 0, go to WATER.
- WATER: zone_valve[cur] = 1, pump_en = 1. remaining decrements on tick.
  - tick with remaining = 1: completion; go to CLOSE with done_pending = 1.
  - empty (checked before tick): go to CLOSE with pause_pending = 1; remaining is kept.
  - zone_req[cur] dropped: go to CLOSE as an abort; no done pulse.
  - Priority when several occur in the same cycle: empty > completion > abort.
- CLOSE: pump_en = 0; zone_valve[cur] held for SETTLE ticks, then dropped. On exit, exactly one of the following applies:
  - done_pending: pulse zone_done[cur] on the exit cycle, set rr = cur+1 mod NZ, go to IDLE.
  - pause_pending: go to WAIT_TANK.
  - abort: set rr = cur+1 mod NZ, go to IDLE.
- WAIT_TANK: valves 0, pump 0, refill_req = 1.
  - When full and fill_busy = 0: refill_req drops, settle counter reloads, go to OPEN for the same zone with the retained remaining.
  - If zone_req[cur] drops while waiting: go to IDLE, refill_req drops, rr advances.
- pump_en is never 1 unless exactly one zone_valve bit is 1 (checkable invariant).
- zone_valve is at most one-hot at all times.
- zone_req changes for non-current zones have no effect until the next SELECT.
- tick exactly on a state-entry cycle is counted. Settle and duration counters only decrement on tick.
- Reset mid-operation: valves and pump drop asynchronously the same instant reset rises; no done pulse is issued.

Test Plan:
- Basic cycle: NZ=4, SETTLE=2, zone_req=0001, dur0=3, nv=111, tick every 4 clks.
  -> valve0 high 2 ticks, then pump_en high for exactly 3 ticks, then valve0 held 2 more ticks.
  -> single zone_done[0] pulse; busy falls; rr=1.
- Round-robin: zone_req=1011 held, all durations 1.
  -> service order 0, 1, 3, 0, 1, 3; no zone is served twice while others are pending.
- Empty mid-water: dur2=10; set nv=000 after 4 WATER ticks.
  -> pump_en drops immediately, valve closes after SETTLE, refill_req=1.
  -> restore nv=111, fill_busy=0: OPEN again for zone 2, then exactly 6 more pump ticks, then zone_done[2].
- Zero duration / abort: dur1=0, req1=1 -> zone_done[1] pulse in SELECT, zone_valve stays 0. Separately, drop req3 during WATER -> CLOSE, no zone_done[3].
- Sensor fault: nv=101 in IDLE with a request pending -> sensor_fault=1, WAIT_TANK, refill_req=1; fault stays 1 after nv returns to 111.
- Async reset during WATER: zone_valve=0 and pump_en=0 without waiting for a clk edge; state IDLE, rr=0, sensor_fault=0.
